// File: rtl/mte_op_scheduler.sv
// Sequencing controller for the MAC-then-encrypt engine: round-robin arbitration of two
// requesters, shared key register, one engine operation in flight, valid/ready response port.
module mte_op_scheduler #(
  parameter int N       = 8,
  parameter int ENG_LAT = 2
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           key_load,
  input  logic [N-1:0]   key_in,
  output logic           key_loaded,
  input  logic [1:0]     req_valid,
  output logic [1:0]     req_ready,
  input  logic [1:0]     req_sel,
  input  logic [4*N-1:0] req_data,
  output logic [N-1:0]   eng_key,
  output logic [2*N-1:0] eng_in,
  output logic           eng_sel,
  output logic           eng_start,
  input  logic [2*N-1:0] eng_out,
  input  logic           eng_eq,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic           rsp_id,
  output logic [2*N-1:0] rsp_data,
  output logic           rsp_auth_ok,
  output logic           busy
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [N-1:0]   r_key;
  logic           r_key_loaded;
  logic           r_last_grant;
  logic [3:0]     r_cnt;
  logic [2*N-1:0] r_eng_in;
  logic           r_eng_sel;
  logic           r_eng_start;
  logic           r_rsp_id;
  logic [2*N-1:0] r_rsp_data;
  logic           r_rsp_auth_ok;

  logic [1:0]     w_eligible;
  logic [1:0]     w_grant;
  logic           w_accept;
  logic           w_win;
  logic           w_capture;

  // A key_load in IDLE wins over any request; the grant slips by one cycle.
  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    w_eligible = 2'b00;
    w_grant    = 2'b00;
    if (r_state == S_IDLE) begin
      w_eligible = req_valid & {2{r_key_loaded & ~key_load}};
    end
    w_grant = w_eligible;
    if (w_eligible == 2'b11) begin
      w_grant = r_last_grant ? 2'b01 : 2'b10;
    end
  end

  assign w_accept  = |w_grant;
  assign w_win     = w_grant[1];
  assign w_capture = (r_state == S_WAIT) && (r_cnt == 4'd1);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so all flops update together.
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    rsp_valid   = 1'b0;
    busy        = 1'b1;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (w_accept) w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (w_capture) w_state_nxt = S_RESP;
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_key         <= '0;
      r_key_loaded  <= 1'b0;
      r_last_grant  <= 1'b1;
      r_cnt         <= '0;
      r_eng_in      <= '0;
      r_eng_sel     <= 1'b0;
      r_eng_start   <= 1'b0;
      r_rsp_id      <= 1'b0;
      r_rsp_data    <= '0;
      r_rsp_auth_ok <= 1'b0;
    end else begin
      r_eng_start <= 1'b0;
      if ((r_state == S_IDLE) && key_load) begin
        r_key        <= key_in;
        r_key_loaded <= 1'b1;
      end
      if (w_accept) begin
        r_eng_in     <= w_win ? req_data[4*N-1:2*N] : req_data[2*N-1:0];
        r_eng_sel    <= req_sel[w_win];
        r_rsp_id     <= w_win;
        r_last_grant <= w_win;
        r_cnt        <= 4'(ENG_LAT);
        r_eng_start  <= 1'b1;
      end
      if (r_state == S_WAIT) begin
        r_cnt <= r_cnt - 4'd1;
      end
      // A failed MAC check on decrypt suppresses the plaintext entirely.
      if (w_capture) begin
        if (r_eng_sel) begin
          r_rsp_data    <= eng_out;
          r_rsp_auth_ok <= 1'b1;
        end else if (eng_eq) begin
          r_rsp_data    <= {{N{1'b0}}, eng_out[2*N-1:N]};
          r_rsp_auth_ok <= 1'b1;
        end else begin
          r_rsp_data    <= '0;
          r_rsp_auth_ok <= 1'b0;
        end
      end
    end
  end

  assign req_ready   = w_grant;
  assign key_loaded  = r_key_loaded;
  assign eng_key     = r_key;
  assign eng_in      = r_eng_in;
  assign eng_sel     = r_eng_sel;
  assign eng_start   = r_eng_start;
  assign rsp_id      = r_rsp_id;
  assign rsp_data    = r_rsp_data;
  assign rsp_auth_ok = r_rsp_auth_ok;

endmodule

// File: tb/tb_mte_op_scheduler.sv
// Self-checking bench for mte_op_scheduler: behavioural MTE engine, transaction-level
// reference model compared every cycle, directed scenarios plus randomized traffic.
module tb_mte_op_scheduler;
  localparam int N       = 8;
  localparam int ENG_LAT = 2;

  logic        clock = 1'b0;
  logic        reset;
  logic        key_load;
  logic [7:0]  key_in;
  logic        key_loaded;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [1:0]  req_sel;
  logic [31:0] req_data;
  logic [7:0]  eng_key;
  logic [15:0] eng_in;
  logic        eng_sel;
  logic        eng_start;
  logic [15:0] eng_out;
  logic        eng_eq;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic [15:0] rsp_data;
  logic        rsp_auth_ok;
  logic        busy;

  mte_op_scheduler #(.N(N), .ENG_LAT(ENG_LAT)) dut (
    .clock(clock), .reset(reset), .key_load(key_load), .key_in(key_in),
    .key_loaded(key_loaded), .req_valid(req_valid), .req_ready(req_ready),
    .req_sel(req_sel), .req_data(req_data), .eng_key(eng_key), .eng_in(eng_in),
    .eng_sel(eng_sel), .eng_start(eng_start), .eng_out(eng_out), .eng_eq(eng_eq),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_auth_ok(rsp_auth_ok), .busy(busy)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Engine arithmetic: MAC over the data byte, then a keyed XOR pad and a 3-bit rotate.
  function automatic logic [7:0] mac_f(input logic [7:0] d, input logic [7:0] k);
    logic [7:0] y;
    y = (d ^ k) + 8'h37;
    return {y[4:0], y[7:5]} ^ k;
  endfunction

  function automatic logic [15:0] enc_f(input logic [15:0] w, input logic [7:0] k);
    logic [15:0] x;
    x = w ^ {k, k ^ 8'h5A};
    return {x[12:0], x[15:13]};
  endfunction

  function automatic logic [15:0] dec_f(input logic [15:0] c, input logic [7:0] k);
    logic [15:0] x;
    x = {c[2:0], c[15:3]};
    return x ^ {k, k ^ 8'h5A};
  endfunction

  // Engine output is correct only on the cycle ENG_LAT-1 after the start pulse; garbage otherwise.
  int age = 0;
  always @(posedge clock) begin
    if (eng_start) age <= 1;
    else if (age != 0 && age < 15) age <= age + 1;
  end

  logic [15:0] eng_plain;
  always_comb begin
    eng_plain = dec_f(eng_in, eng_key);
    eng_out   = eng_sel ? enc_f({eng_in[15:8], mac_f(eng_in[15:8], eng_key)}, eng_key) : eng_plain;
    eng_eq    = (eng_plain[7:0] == mac_f(eng_plain[15:8], eng_key));
    if (age != ENG_LAT - 1) begin
      eng_out = ~eng_out;
      eng_eq  = ~eng_eq;
    end
  end

  // Transaction-level reference: one op outstanding, accepted at m_acc, answer due ENG_LAT+1 later.
  logic [7:0]  m_key;
  bit          m_loaded;
  bit          m_last;
  bit          m_busy;
  bit          m_id;
  bit          m_sel;
  int          m_acc;
  logic [15:0] m_word;
  logic [15:0] m_rdata;
  bit          m_rok;

  always @(negedge clock) begin
    logic [1:0]  e_rdy;
    bit          e_rv;
    logic [15:0] p;
    if (reset) begin
      check("rst_busy", busy, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_req_ready", req_ready, 0);
      check("rst_key_loaded", key_loaded, 0);
      check("rst_eng_key", eng_key, 0);
      check("rst_eng_in", eng_in, 0);
      check("rst_eng_sel", eng_sel, 0);
      check("rst_eng_start", eng_start, 0);
      check("rst_rsp_id", rsp_id, 0);
      check("rst_rsp_data", rsp_data, 0);
      check("rst_rsp_auth_ok", rsp_auth_ok, 0);
      m_key    = 8'h00;
      m_loaded = 1'b0;
      m_last   = 1'b1;
      m_busy   = 1'b0;
    end else begin
      e_rdy = 2'b00;
      if (!m_busy && m_loaded && !key_load) begin
        e_rdy = req_valid;
        if (req_valid == 2'b11) e_rdy = m_last ? 2'b01 : 2'b10;
      end
      e_rv = m_busy && (cyc >= m_acc + ENG_LAT + 1);
      check("req_ready", req_ready, e_rdy);
      check("rsp_valid", rsp_valid, e_rv);
      check("busy", busy, m_busy);
      check("eng_start", eng_start, m_busy && (cyc == m_acc + 1));
      check("key_loaded", key_loaded, m_loaded);
      check("eng_key", eng_key, m_key);
      if (m_busy) begin
        check("eng_in", eng_in, m_word);
        check("eng_sel", eng_sel, m_sel);
      end
      if (e_rv) begin
        check("rsp_id", rsp_id, m_id);
        check("rsp_data", rsp_data, m_rdata);
        check("rsp_auth_ok", rsp_auth_ok, m_rok);
      end
      if (e_rv && rsp_ready) begin
        m_busy = 1'b0;
      end else if (!m_busy) begin
        if (key_load) begin
          m_key    = key_in;
          m_loaded = 1'b1;
        end else if (e_rdy != 2'b00) begin
          m_id   = e_rdy[1];
          m_busy = 1'b1;
          m_acc  = cyc;
          m_last = m_id;
          m_word = m_id ? req_data[31:16] : req_data[15:0];
          m_sel  = req_sel[m_id];
          if (m_sel) begin
            m_rdata = enc_f({m_word[15:8], mac_f(m_word[15:8], m_key)}, m_key);
            m_rok   = 1'b1;
          end else begin
            p       = dec_f(m_word, m_key);
            m_rok   = (p[7:0] == mac_f(p[15:8], m_key));
            m_rdata = m_rok ? {8'h00, p[15:8]} : 16'h0000;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Present a request and hold it until granted; returns in the cycle after the accept.
  task automatic send(input int id, input logic sel, input logic [15:0] w, output int t_acc);
    req_valid[id] = 1'b1;
    req_sel[id]   = sel;
    req_data[id*16 +: 16] = w;
    t_acc = -1;
    for (int n = 0; n < 60 && t_acc < 0; n++) begin
      @(negedge clock);
      if (req_ready[id]) t_acc = cyc;
      tick();
    end
    req_valid[id] = 1'b0;
    if (t_acc < 0) check("grant_timeout", 0, 1);
  endtask

  logic [15:0] got_data;
  logic        got_id;
  logic        got_ok;

  task automatic wait_rsp(output int t_rsp, output int t_start);
    t_rsp   = -1;
    t_start = -1;
    for (int n = 0; n < 40 && t_rsp < 0; n++) begin
      @(negedge clock);
      if (eng_start && t_start < 0) t_start = cyc;
      if (rsp_valid) begin
        t_rsp    = cyc;
        got_data = rsp_data;
        got_id   = rsp_id;
        got_ok   = rsp_auth_ok;
      end
      tick();
    end
    if (t_rsp < 0) check("rsp_timeout", 0, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          t_acc, t_rsp, t_start, t_key, ng;
    bit          grants[4];
    logic [15:0] hold_data;
    logic [1:0]  prev_rdy;
    logic [7:0]  d;
    logic [15:0] w;

    reset = 1'b1; key_load = 1'b0; key_in = 8'h00; req_valid = 2'b00;
    req_sel = 2'b00; req_data = 32'h0; rsp_ready = 1'b1;
    repeat (2) tick();
    reset = 1'b0;

    // No key loaded: a pending request is never granted.
    req_valid = 2'b01; req_sel = 2'b01; req_data[15:0] = 16'hA500;
    repeat (3) begin
      @(negedge clock);
      check("nokey_ready", req_ready, 2'b00);
      tick();
    end
    key_load = 1'b1; key_in = 8'h3C;
    @(negedge clock);
    check("keyload_cycle_ready", req_ready, 2'b00);
    t_key = cyc;
    tick();
    key_load = 1'b0;

    // Encrypt A5 on requester 0.
    send(0, 1'b1, 16'hA500, t_acc);
    check("first_grant_delay", t_acc - t_key, 1);
    wait_rsp(t_rsp, t_start);
    check("enc_start_lat", t_start - t_acc, 1);
    check("enc_rsp_lat", t_rsp - t_acc, 3);
    check("enc_data", got_data, 16'hCEE4);
    check("enc_id", got_id, 0);
    check("enc_ok", got_ok, 1);

    // Decrypt the cipher on requester 1, then a corrupted copy.
    send(1, 1'b0, 16'hCEE4, t_acc);
    wait_rsp(t_rsp, t_start);
    check("dec_data", got_data, 16'h00A5);
    check("dec_ok", got_ok, 1);
    check("dec_id", got_id, 1);
    send(1, 1'b0, 16'hCEE5, t_acc);
    wait_rsp(t_rsp, t_start);
    check("bad_data", got_data, 16'h0000);
    check("bad_ok", got_ok, 0);

    // Both requesters continuously valid: grants alternate starting with 0.
    req_valid = 2'b11; req_sel = 2'b11; req_data = {16'h2200, 16'h1100};
    ng = 0;
    for (int n = 0; n < 80 && ng < 4; n++) begin
      @(negedge clock);
      if (req_ready != 2'b00) begin
        grants[ng] = req_ready[1];
        ng++;
      end
      tick();
      if (ng == 4) rsp_ready = 1'b0;
    end
    check("grant_count", ng, 4);
    for (int i = 0; i < 4; i++) check("grant_seq", grants[i], i % 2);

    // Stalled response stays stable and blocks further grants.
    for (int n = 0; n < 20 && !rsp_valid; n++) tick();
    @(negedge clock);
    hold_data = rsp_data;
    tick();
    for (int n = 0; n < 4; n++) begin
      @(negedge clock);
      check("stall_valid", rsp_valid, 1);
      check("stall_data", rsp_data, hold_data);
      check("stall_id", rsp_id, 1);
      check("stall_ready", req_ready, 2'b00);
      tick();
    end
    rsp_ready = 1'b1;
    tick();

    // key_load in IDLE with both requesting: key taken, grant deferred, requester 0 next.
    key_load = 1'b1; key_in = 8'h5E;
    @(negedge clock);
    check("kl_idle_ready", req_ready, 2'b00);
    tick();
    key_load = 1'b0;
    @(negedge clock);
    check("kl_idle_key", eng_key, 8'h5E);
    check("kl_next_grant", req_ready, 2'b01);
    tick();
    req_valid = 2'b00;
    key_load = 1'b1; key_in = 8'hFF;
    tick();
    key_load = 1'b0;
    @(negedge clock);
    check("kl_wait_key", eng_key, 8'h5E);
    wait_rsp(t_rsp, t_start);

    // Reset in the middle of WAIT drops the op.
    send(0, 1'b1, 16'h3300, t_acc);
    reset = 1'b1;
    @(negedge clock);
    check("midrst_busy", busy, 0);
    check("midrst_eng_start", eng_start, 0);
    check("midrst_key_loaded", key_loaded, 0);
    tick();
    reset = 1'b0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clock);
      check("postrst_no_rsp", rsp_valid, 0);
      tick();
    end

    // Randomized traffic with protocol-compliant requesters.
    for (int c = 0; c < 1500; c++) begin
      @(negedge clock);
      prev_rdy = req_ready;
      tick();
      for (int i = 0; i < 2; i++) begin
        if (!req_valid[i] || prev_rdy[i]) begin
          req_valid[i] = ($urandom_range(2) != 0);
          req_sel[i]   = 1'($urandom_range(1));
          d = 8'($urandom);
          if (!req_sel[i] && $urandom_range(2) != 0) begin
            w = enc_f({d, mac_f(d, m_key)}, m_key);
            if ($urandom_range(3) == 0) w[$urandom_range(15)] ^= 1'b1;
          end else begin
            w = {d, 8'($urandom)};
          end
          req_data[i*16 +: 16] = w;
        end
      end
      key_load  = ($urandom_range(15) == 0);
      key_in    = 8'($urandom);
      rsp_ready = ($urandom_range(2) != 0);
      reset     = (c == 700);
    end
    reset = 1'b0; key_load = 1'b0; req_valid = 2'b00; rsp_ready = 1'b1;
    repeat (10) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
